// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } imem_arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } imem_req_id_e;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational two-way grant: fixed CPU priority, or round-robin when IMEM_ARB_RR_EN is defined.
// ptr_i=0 favours the CPU, ptr_i=1 favours debug; grant is one-hot {dbg, cpu} or zero.
module imem_arb_pick (
  input  logic       c_vld_i,
  input  logic       d_vld_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

`ifdef IMEM_ARB_RR_EN
  always_comb begin
    gnt_o = 2'b00;
    if (c_vld_i && (!d_vld_i || !ptr_i)) begin
      gnt_o = 2'b01;
    end else if (d_vld_i) begin
      gnt_o = 2'b10;
    end
  end
`else
  logic ptr_unused;
  assign ptr_unused = ptr_i;

  always_comb begin
    gnt_o = 2'b00;
    if (c_vld_i) begin
      gnt_o = 2'b01;
    end else if (d_vld_i) begin
      gnt_o = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Shares a combinational-read instruction memory between CPU fetch and debug: IDLE->READ->RESP,
// response two cycles after handshake and held until the owner's rsp_ready; IMEM_ARB_RR_EN enables round-robin.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP_WORD   = IMEM_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req_valid,
  input  logic [31:0] c_req_addr,
  output logic        c_req_ready,
  output logic        c_rsp_valid,
  output logic [31:0] c_rsp_data,
  output logic        c_rsp_err,
  input  logic        c_rsp_ready,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  input  logic        d_rsp_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data
);

  localparam int HI_LSB = DEPTH_LOG2 + 2;

  imem_arb_state_e state_q, state_d;
  imem_req_id_e    owner_q, owner_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic            rr_ptr;
  logic [1:0]      gnt;
  logic            addr_err;

  imem_arb_pick u_pick (
    .c_vld_i (c_req_valid),
    .d_vld_i (d_req_valid),
    .ptr_i   (rr_ptr),
    .gnt_o   (gnt)
  );

`ifdef IMEM_ARB_RR_EN
  logic rr_q, rr_d;

  // After a CPU grant the pointer swings to debug, and vice versa.
  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && gnt != 2'b00) begin
      rr_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign rr_ptr = rr_q;
`else
  assign rr_ptr = 1'b0;
`endif

  assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> HI_LSB) != 32'd0);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    data_d      = data_q;
    err_d       = err_q;
    c_req_ready = 1'b0;
    d_req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        c_req_ready = gnt[0];
        d_req_ready = gnt[1];
        if (gnt[0]) begin
          owner_d = REQ_CPU;
          addr_d  = c_req_addr;
          state_d = READ;
        end else if (gnt[1]) begin
          owner_d = REQ_DBG;
          addr_d  = d_req_addr;
          state_d = READ;
        end
      end
      READ: begin
        err_d   = addr_err;
        data_d  = addr_err ? NOP_WORD : mem_data;
        state_d = RESP;
      end
      RESP: begin
        if ((owner_q == REQ_CPU) ? c_rsp_ready : d_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= REQ_CPU;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr    = addr_q;
  assign c_rsp_valid = (state_q == RESP) && (owner_q == REQ_CPU);
  assign d_rsp_valid = (state_q == RESP) && (owner_q == REQ_DBG);
  assign c_rsp_data  = data_q;
  assign d_rsp_data  = data_q;
  assign c_rsp_err   = err_q;
  assign d_rsp_err   = err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 256-word combinational memory.
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic        c_req_valid, c_req_ready, c_rsp_valid, c_rsp_err, c_rsp_ready;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_ready;
  logic [31:0] c_req_addr, c_rsp_data, d_req_addr, d_rsp_data;
  logic [31:0] mem_addr, mem_data;
  logic [31:0] mem [0:255];

  int n_vec;
  int n_bad;

  imem_arbiter #(.DEPTH_LOG2(8), .NOP_WORD(32'h0000_0013)) dut (
    .clk         (clk),
    .reset       (reset),
    .c_req_valid (c_req_valid),
    .c_req_addr  (c_req_addr),
    .c_req_ready (c_req_ready),
    .c_rsp_valid (c_rsp_valid),
    .c_rsp_data  (c_rsp_data),
    .c_rsp_err   (c_rsp_err),
    .c_rsp_ready (c_rsp_ready),
    .d_req_valid (d_req_valid),
    .d_req_addr  (d_req_addr),
    .d_req_ready (d_req_ready),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .d_rsp_err   (d_rsp_err),
    .d_rsp_ready (d_rsp_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data)
  );

  assign mem_data = mem[mem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if ({c_rsp_valid, d_rsp_valid, c_rsp_err, d_rsp_err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 0000", {c_rsp_valid, d_rsp_valid, c_rsp_err, d_rsp_err});
    end
    n_vec++;
    if ({c_rsp_data, mem_addr} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_regs: data %h mem_addr %h expected 0/0", c_rsp_data, mem_addr);
    end
    n_vec++;
    if ({c_req_ready, d_req_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready_idle: got %b expected 00", {c_req_ready, d_req_ready});
    end
    c_req_valid = 1'b1;
    d_req_valid = 1'b1;
    #1;
    n_vec++;
    if ({c_req_ready, d_req_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_priority: got %b expected 10", {c_req_ready, d_req_ready});
    end
    c_req_valid = 1'b0;
    d_req_valid = 1'b0;
    tick;
  endtask

  task automatic test_cpu_single;
    c_req_addr  = 32'h0;
    c_req_valid = 1'b1;
    #1;
    n_vec++;
    if (c_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ready: got %b expected 1", c_req_ready);
    end
    tick;
    c_req_valid = 1'b0;
    n_vec++;
    if ({mem_addr, c_rsp_valid, d_rsp_valid} !== {32'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL single_read: mem_addr %h vld %b expected 0/00", mem_addr, {c_rsp_valid, d_rsp_valid});
    end
    tick;
    n_vec++;
    if ({c_rsp_valid, d_rsp_valid, c_rsp_err, c_rsp_data} !== {3'b100, 32'h0050_0513}) begin
      n_bad++;
      $display("FAIL single_rsp: vld %b err %b data %h expected 10/0/00500513",
               {c_rsp_valid, d_rsp_valid}, c_rsp_err, c_rsp_data);
    end
    tick;
    n_vec++;
    if ({c_rsp_valid, d_rsp_valid, c_rsp_data} !== {2'b00, 32'h0050_0513}) begin
      n_bad++;
      $display("FAIL single_done: vld %b data %h expected 00/00500513", {c_rsp_valid, d_rsp_valid}, c_rsp_data);
    end
  endtask

  task automatic test_contention;
    logic [2:0] dbg_seq;
    logic       exp_d;
`ifdef IMEM_ARB_RR_EN
    dbg_seq = 3'b010;
`else
    dbg_seq = 3'b000;
`endif
    reset = 1'b1;
    tick;
    reset = 1'b0;
    c_req_addr  = 32'h4;
    d_req_addr  = 32'h8;
    c_req_valid = 1'b1;
    d_req_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if (r == 3) c_req_valid = 1'b0;
      exp_d = (r == 3) ? 1'b1 : dbg_seq[r];
      #1;
      n_vec++;
      if ({c_req_ready, d_req_ready} !== {~exp_d, exp_d}) begin
        n_bad++;
        $display("FAIL contend_grant[%0d]: got %b expected %b", r, {c_req_ready, d_req_ready}, {~exp_d, exp_d});
      end
      tick;
      n_vec++;
      if ({c_req_ready, d_req_ready, mem_addr} !== {2'b00, (exp_d ? 32'h8 : 32'h4)}) begin
        n_bad++;
        $display("FAIL contend_read[%0d]: ready %b mem_addr %h", r, {c_req_ready, d_req_ready}, mem_addr);
      end
      tick;
      n_vec++;
      if ({c_rsp_valid, d_rsp_valid, (exp_d ? d_rsp_data : c_rsp_data)} !==
          {~exp_d, exp_d, mem[exp_d ? 2 : 1]}) begin
        n_bad++;
        $display("FAIL contend_rsp[%0d]: vld %b data %h expected %b/%h", r, {c_rsp_valid, d_rsp_valid},
                 exp_d ? d_rsp_data : c_rsp_data, {~exp_d, exp_d}, mem[exp_d ? 2 : 1]);
      end
      tick;
    end
    d_req_valid = 1'b0;
    c_req_valid = 1'b0;
  endtask

  task automatic test_errors;
    d_req_addr  = 32'h6;
    d_req_valid = 1'b1;
    tick;
    d_req_valid = 1'b0;
    tick;
    n_vec++;
    if ({d_rsp_valid, c_rsp_valid, d_rsp_err, d_rsp_data} !== {3'b101, 32'h0000_0013}) begin
      n_bad++;
      $display("FAIL misaligned: vld %b err %b data %h expected 10/1/00000013",
               {d_rsp_valid, c_rsp_valid}, d_rsp_err, d_rsp_data);
    end
    tick;
    c_req_addr  = 32'h400;
    c_req_valid = 1'b1;
    tick;
    c_req_valid = 1'b0;
    n_vec++;
    if (mem_addr !== 32'h400) begin
      n_bad++;
      $display("FAIL range_addr: got %h expected 00000400", mem_addr);
    end
    tick;
    n_vec++;
    if ({c_rsp_valid, c_rsp_err, c_rsp_data} !== {2'b11, 32'h0000_0013}) begin
      n_bad++;
      $display("FAIL out_of_range: vld %b err %b data %h expected 1/1/00000013", c_rsp_valid, c_rsp_err, c_rsp_data);
    end
    tick;
    c_req_addr  = 32'h3FC;
    c_req_valid = 1'b1;
    tick;
    c_req_valid = 1'b0;
    tick;
    n_vec++;
    if ({c_rsp_valid, c_rsp_err, c_rsp_data} !== {2'b10, mem[255]}) begin
      n_bad++;
      $display("FAIL top_word: vld %b err %b data %h expected 1/0/%h", c_rsp_valid, c_rsp_err, c_rsp_data, mem[255]);
    end
    tick;
  endtask

  task automatic test_backpressure;
    c_req_addr  = 32'hC;
    c_req_valid = 1'b1;
    c_rsp_ready = 1'b0;
    tick;
    c_req_valid = 1'b0;
    d_req_addr  = 32'h10;
    d_req_valid = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({c_rsp_valid, d_req_ready, c_rsp_data} !== {2'b10, mem[3]}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: vld %b d_rdy %b data %h expected 1/0/%h",
                 i, c_rsp_valid, d_req_ready, c_rsp_data, mem[3]);
      end
      tick;
    end
    c_rsp_ready = 1'b1;
    #1;
    n_vec++;
    if ({c_rsp_valid, d_req_ready, c_rsp_data} !== {2'b10, mem[3]}) begin
      n_bad++;
      $display("FAIL bp_release: vld %b d_rdy %b data %h", c_rsp_valid, d_req_ready, c_rsp_data);
    end
    tick;
    n_vec++;
    if ({c_rsp_valid, d_req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_complete: vld %b d_rdy %b expected 0/1", c_rsp_valid, d_req_ready);
    end
    d_req_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    c_req_addr  = 32'h14;
    c_req_valid = 1'b1;
    tick;
    c_req_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_vec++;
    if ({c_rsp_valid, d_rsp_valid, mem_addr, c_rsp_data} !== 66'd0) begin
      n_bad++;
      $display("FAIL rst_read: vld %b mem_addr %h data %h expected 0", {c_rsp_valid, d_rsp_valid}, mem_addr, c_rsp_data);
    end
    tick;
    tick;
    n_vec++;
    if ({c_rsp_valid, d_rsp_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_read_stale: vld %b expected 00", {c_rsp_valid, d_rsp_valid});
    end
    d_req_addr  = 32'h7;
    d_req_valid = 1'b1;
    d_rsp_ready = 1'b0;
    tick;
    d_req_valid = 1'b0;
    tick;
    n_vec++;
    if ({d_rsp_valid, d_rsp_err} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_pre_resp: vld %b err %b expected 1/1", d_rsp_valid, d_rsp_err);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_vec++;
    if ({c_rsp_valid, d_rsp_valid, d_rsp_err, mem_addr, d_rsp_data} !== 67'd0) begin
      n_bad++;
      $display("FAIL rst_resp: vld %b err %b mem_addr %h data %h expected 0",
               {c_rsp_valid, d_rsp_valid}, d_rsp_err, mem_addr, d_rsp_data);
    end
    d_rsp_ready = 1'b1;
    tick;
    tick;
    c_req_valid = 1'b1;
    #1;
    n_vec++;
    if ({c_rsp_valid, d_rsp_valid, c_req_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL rst_resp_idle: vld %b c_rdy %b expected 00/1", {c_rsp_valid, d_rsp_valid}, c_req_ready);
    end
    c_req_valid = 1'b0;
    tick;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h0050_0513;
    reset       = 1'b1;
    c_req_valid = 1'b0;
    d_req_valid = 1'b0;
    c_req_addr  = 32'h0;
    d_req_addr  = 32'h0;
    c_rsp_ready = 1'b1;
    d_rsp_ready = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    test_reset;
    test_cpu_single;
    test_contention;
    test_errors;
    test_backpressure;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
